bisqrt_window_sched: RTL and testbench



---
 rtl/bisqrt_sched_pkg.sv | 23 ++
 rtl/bisqrt_window_sched_rr_arbiter.sv | 33 +++
 rtl/bisqrt_window_sched.sv | 112 +++++++++++
 tb/tb_bisqrt_window_sched.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bisqrt_sched_pkg.sv
// Shared types and width helpers for the bipolar sqrt window scheduler.
package bisqrt_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_WARM  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic int idx_w(input int nreq);
        return (nreq < 2) ? 1 : $clog2(nreq);
    endfunction

    // Timer holds at most max(warm, 2^loglen)-1, since it counts down to zero.
    function automatic int tmr_w(input int warm, input int loglen);
        int span;
        span = (warm > (1 << loglen)) ? warm : (1 << loglen);
        return (span < 2) ? 1 : $clog2(span);
    endfunction

endpackage

// File: rtl/bisqrt_window_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter
    import bisqrt_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);

    int   pos;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int i = 0; i < NREQ; i++) begin
            pos = int'(ptr) + i;
            if (pos >= NREQ) pos = pos - NREQ;
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/bisqrt_window_sched.sv
// Shares one unary bipolar sqrt kernel among NREQ requesters, one window per grant:
// kernel reset, WARM uncounted cycles, 2^LOGLEN counted cycles. Option: BISQRT_SCHED_ABORT_EN.
module bisqrt_window_sched
    import bisqrt_sched_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int LOGLEN = 8,
    parameter int WARM   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   bit_in,
    output logic [NREQ-1:0]   gnt,
    output logic              k_rst_n,
    output logic              k_in,
    input  logic              k_out,
    output logic [NREQ-1:0]   done,
    output logic [LOGLEN:0]   result,
    output logic              busy
);

    localparam int IW = idx_w(NREQ);
    localparam int TW = tmr_w(WARM, LOGLEN);
    localparam int CW = LOGLEN + 1;
    localparam logic [TW-1:0] RUN_LD  = TW'((1 << LOGLEN) - 1);
    localparam logic [TW-1:0] WARM_LD = TW'((WARM > 0) ? WARM - 1 : 0);

    state_t          state, nxt;
    logic [IW-1:0]   g, ptr, g_inc, arb_ptr, arb_idx;
    logic [NREQ-1:0] arb_gnt;
    logic [TW-1:0]   tmr;
    logic [CW-1:0]   cnt, cnt_fin;
    logic            tmr_zero, any_req, feeding, abort;

    assign any_req  = |req;
    assign tmr_zero = (tmr == '0);
    assign feeding  = (state == ST_WARM) || (state == ST_RUN);
    assign g_inc    = (g == IW'(NREQ - 1)) ? '0 : g + IW'(1);
    // In DONE the pointer is already treated as g+1, so g ends up last in line.
    assign arb_ptr  = (state == ST_DONE) ? g_inc : ptr;
    assign cnt_fin  = cnt + CW'(k_out);
    assign k_in     = feeding & bit_in[g];
    assign busy     = (state != ST_IDLE);

`ifdef BISQRT_SCHED_ABORT_EN
    assign abort = feeding & ~req[g];
`else
    assign abort = 1'b0;
`endif

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req (req),
        .ptr (arb_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:  if (any_req) nxt = ST_FLUSH;
            ST_FLUSH: nxt = (WARM == 0) ? ST_RUN : ST_WARM;
            ST_WARM:  if (tmr_zero) nxt = ST_RUN;
            ST_RUN:   if (tmr_zero) nxt = ST_DONE;
            ST_DONE:  nxt = any_req ? ST_FLUSH : ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
        if (abort) nxt = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            g       <= '0;
            ptr     <= '0;
            tmr     <= '0;
            cnt     <= '0;
            gnt     <= '0;
            done    <= '0;
            result  <= '0;
            k_rst_n <= 1'b0;
        end else begin
            state   <= nxt;
            k_rst_n <= (nxt != ST_FLUSH);
            done    <= '0;
            if ((state == ST_DONE) || abort) ptr <= g_inc;
            if (nxt == ST_FLUSH) begin
                g   <= arb_idx;
                gnt <= arb_gnt;
                cnt <= '0;
            end else if (nxt == ST_IDLE) begin
                gnt <= '0;
            end
            case (state)
                ST_FLUSH: tmr <= (WARM == 0) ? RUN_LD : WARM_LD;
                ST_WARM:  tmr <= tmr_zero ? RUN_LD : tmr - TW'(1);
                ST_RUN: begin
                    cnt <= cnt_fin;
                    tmr <= tmr - TW'(1);
                end
                default: ;
            endcase
            // Last RUN cycle's k_out is folded in here so result is valid during DONE.
            if (nxt == ST_DONE) begin
                done   <= NREQ'(1) << g;
                result <= cnt_fin;
            end
        end
    end

endmodule

// File: tb/tb_bisqrt_window_sched.sv
// Scoreboard bench for bisqrt_window_sched: window-position reference model plus directed phases.
module tb_bisqrt_window_sched;

    localparam int NREQ    = 4;
    localparam int LOGLEN  = 4;
    localparam int WARM    = 2;
    localparam int RUNLEN  = 1 << LOGLEN;
    localparam int DONEPOS = 1 + WARM + RUNLEN;
`ifdef BISQRT_SCHED_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    logic            clk = 1'b0, rst_n = 1'b0;
    logic [NREQ-1:0] req = '0, bit_in = '0;
    logic [NREQ-1:0] gnt, done;
    logic            k_rst_n, k_in, busy;
    logic            k_out = 1'b0;
    logic [LOGLEN:0] result;

    int tests = 0, fails = 0, cyc = 0;

    typedef struct {int idx; int cnt;} exp_t;
    exp_t sbq[$];
    exp_t e;

    // Reference model: position within the current window (0 = kernel reset cycle, DONEPOS = done cycle).
    int in_win = 0, pos = 0, mg = 0, mptr = 0, mcnt = 0, mres = 0, kr = 0;
    int kmode = 0;

    bisqrt_window_sched #(.NREQ(NREQ), .LOGLEN(LOGLEN), .WARM(WARM)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .bit_in  (bit_in),
        .gnt     (gnt),
        .k_rst_n (k_rst_n),
        .k_in    (k_in),
        .k_out   (k_out),
        .done    (done),
        .result  (result),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick(input int p, input logic [NREQ-1:0] r);
        for (int i = 0; i < NREQ; i++)
            if (r[(p + i) % NREQ]) return (p + i) % NREQ;
        return -1;
    endfunction

    task automatic start_win();
        mg = pick(mptr, req);
        pos = 0;
        mcnt = 0;
        in_win = 1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_win = 0; pos = 0; mptr = 0; mcnt = 0; mres = 0; kr = 0;
            sbq.delete();
        end else begin
            cyc++;
            if (in_win == 0) begin
                if (req != 0) start_win();
            end else if (ABORT && pos >= 1 && pos < DONEPOS && !req[mg]) begin
                in_win = 0;
                mptr = (mg + 1) % NREQ;
            end else if (pos == DONEPOS) begin
                mptr = (mg + 1) % NREQ;
                if (req != 0) start_win();
                else in_win = 0;
            end else begin
                if (pos > WARM) mcnt += int'(k_out);
                if (pos == DONEPOS - 1) begin
                    mres = mcnt;
                    sbq.push_back('{mg, mcnt});
                end
                pos++;
            end
            kr = (in_win != 0 && pos == 0) ? 0 : 1;
        end
    end

    // Requester streams and kernel output, changed away from the active edge.
    always @(posedge clk) begin
        #1;
        bit_in = NREQ'($urandom);
        case (kmode)
            0: k_out = 1'b1;
            1: k_out = (in_win != 0) && ((pos >= 1 && pos <= WARM) ||
                       (pos > WARM && pos < DONEPOS && (pos - WARM - 1) % 2 == 0));
            default: k_out = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        chk("gnt", int'(gnt), (in_win != 0) ? (1 << mg) : 0);
        chk("busy", int'(busy), (in_win != 0) ? 1 : 0);
        chk("k_rst_n", int'(k_rst_n), kr);
        chk("k_in", int'(k_in), (in_win != 0 && pos >= 1 && pos < DONEPOS) ? int'(bit_in[mg]) : 0);
        chk("done", int'(done), (in_win != 0 && pos == DONEPOS) ? (1 << mg) : 0);
        chk("result", int'(result), mres);
        if (done != 0) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: done=%0d with no window expected (cycle %0d)", done, cyc);
            end else begin
                e = sbq.pop_front();
                chk("sb_done", int'(done), 1 << e.idx);
                chk("sb_result", int'(result), e.cnt);
            end
        end
    end

    task automatic wait_done(input int budget, output int idx);
        idx = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done != 0) begin
                for (int b = 0; b < NREQ; b++) if (done[b]) idx = b;
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL wait_done: no done pulse within %0d cycles (cycle %0d)", budget, cyc);
    endtask

    int idx, snap;
    int order[5];
    int stamp[5];

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_result", int'(result), 0);
        chk("rst_k_rst_n", int'(k_rst_n), 0);
        chk("rst_gnt", int'(gnt), 0);
        #2 rst_n = 1'b1;

        // Single window, kernel output tied high
        @(negedge clk);
        kmode = 0; req = 4'b0001;
        wait_done(40, idx);
        req = '0;
        chk("t1_idx", idx, 0);
        chk("t1_result", int'(result), RUNLEN);
        repeat (3) @(negedge clk);

        // Warm-up ones must not be counted
        kmode = 1; req = 4'b0001;
        wait_done(40, idx);
        req = '0;
        chk("t2_result", int'(result), RUNLEN / 2);
        repeat (3) @(negedge clk);

        // Round robin from a fresh pointer
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        kmode = 2; req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_done(40, order[k]);
            stamp[k] = cyc;
        end
        req = '0;
        for (int k = 0; k < 5; k++) begin
            chk("rr_order", order[k], k % NREQ);
            if (k > 0) chk("rr_gap", stamp[k] - stamp[k-1], DONEPOS + 1);
        end
        repeat (3) @(negedge clk);

        // Sole requester is re-granted back to back
        req = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            wait_done(40, idx);
            chk("sole_idx", idx, 2);
        end
        req = '0;
        repeat (3) @(negedge clk);

        // Reset in the middle of RUN
        req = 4'b0001;
        repeat (12) @(negedge clk);
        chk("t5_busy_pre", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_gnt", int'(gnt), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_done", int'(done), 0);
        chk("t5_k_rst_n", int'(k_rst_n), 0);
        chk("t5_result", int'(result), 0);
        req = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        wait_done(40, idx);
        chk("t5_idx", idx, 1);
        req = '0;
        repeat (3) @(negedge clk);

        // Requester drops its request during RUN
        snap = int'(result);
        kmode = 2; req = 4'b0001;
        repeat (10) @(negedge clk);
        req = '0;
`ifdef BISQRT_SCHED_ABORT_EN
        repeat (2) @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_result", int'(result), snap);
        repeat (25) @(negedge clk);
`else
        wait_done(30, idx);
        chk("noabort_idx", idx, 0);
`endif
        repeat (3) @(negedge clk);

        if (sbq.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL sb_leftover: %0d expected windows never completed", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
